muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the five-stage MIPS pipeline. It sits beside the EX-stage ALU and owns the architectural HI/LO registers. It executes MULT/MULTU/DIV/DIVU as a 32-iteration shift-add or restoring-divide sequence, and MTHI/MTLO as single-cycle writes. It drives a stall request so the hazard unit holds IF/ID/EX while a result is pending.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_if.sv | 28 ++
 rtl/md_sign_fix.sv | 51 +++++
 rtl/muldiv_seq.sv | 167 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes, state encoding and decode helpers for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    function automatic logic md_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage request / HI-LO result bundle between the pipeline and the multiply/divide sequencer.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             stall_req;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, stall_req, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, stall_req, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/md_sign_fix.sv
// Combinational sign handling: operand magnitudes on entry, product/quotient/remainder correction on exit.
module md_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               op_signed,
    input  logic [WIDTH-1:0]   a_raw,
    input  logic [WIDTH-1:0]   b_raw,
    output logic [WIDTH-1:0]   a_abs,
    output logic [WIDTH-1:0]   b_abs,
    output logic               a_neg,
    output logic               b_neg,
    input  logic               res_signed,
    input  logic               res_div,
    input  logic               res_a_neg,
    input  logic               res_b_neg,
    input  logic               res_dbz,
    input  logic [2*WIDTH-1:0] acc,
    output logic [WIDTH-1:0]   res_hi,
    output logic [WIDTH-1:0]   res_lo
);
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quot;

    always_comb begin
        a_neg = op_signed & a_raw[WIDTH-1];
        b_neg = op_signed & b_raw[WIDTH-1];
        a_abs = a_neg ? -a_raw : a_raw;
        b_abs = b_neg ? -b_raw : b_raw;

        prod = acc;
        rem  = acc[2*WIDTH-1:WIDTH];
        quot = acc[WIDTH-1:0];
        if (res_signed && !res_div && (res_a_neg ^ res_b_neg)) begin
            prod = -acc;
        end
        // Remainder sign fix also restores the original dividend when dividing by zero.
        if (res_signed && res_div) begin
            if (res_a_neg) begin
                rem = -acc[2*WIDTH-1:WIDTH];
            end
            if ((res_a_neg ^ res_b_neg) && !res_dbz) begin
                quot = -acc[WIDTH-1:0];
            end
        end
        res_hi = res_div ? rem  : prod[2*WIDTH-1:WIDTH];
        res_lo = res_div ? quot : prod[WIDTH-1:0];
    end
endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one shift-add or restoring step per cycle.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               signed_q, signed_d;
    logic               div_q, div_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic               dbz_save_q, dbz_save_d;

    logic [WIDTH-1:0]   a_abs, b_abs, res_hi, res_lo, mul_addend;
    logic               a_neg, b_neg;
    logic [WIDTH:0]     mul_sum, div_part, div_diff;

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op_signed  (md_is_signed(bus.op)),
        .a_raw      (bus.a),
        .b_raw      (bus.b),
        .a_abs      (a_abs),
        .b_abs      (b_abs),
        .a_neg      (a_neg),
        .b_neg      (b_neg),
        .res_signed (signed_q),
        .res_div    (div_q),
        .res_a_neg  (a_neg_q),
        .res_b_neg  (b_neg_q),
        .res_dbz    (dvsr_q == '0),
        .acc        (acc_q),
        .res_hi     (res_hi),
        .res_lo     (res_lo)
    );

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_addend = acc_q[0] ? dvsr_q : '0;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        div_part   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff   = div_part - {1'b0, dvsr_q};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        dvsr_d     = dvsr_q;
        signed_d   = signed_q;
        div_d      = div_q;
        a_neg_d    = a_neg_q;
        b_neg_d    = b_neg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;
        dbz_save_d = dbz_save_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    if (md_is_arith(bus.op)) begin
                        state_d    = RUN;
                        cnt_d      = CNT_W'(WIDTH - 1);
                        acc_d      = {{WIDTH{1'b0}}, (md_is_div(bus.op) ? a_abs : b_abs)};
                        dvsr_d     = md_is_div(bus.op) ? b_abs : a_abs;
                        signed_d   = md_is_signed(bus.op);
                        div_d      = md_is_div(bus.op);
                        a_neg_d    = a_neg;
                        b_neg_d    = b_neg;
                        dbz_save_d = dbz_q;
                        dbz_d      = 1'b0;
                    end else if (bus.op == MD_MTHI) begin
                        hi_d   = bus.a;
                        done_d = 1'b1;
                    end else if (bus.op == MD_MTLO) begin
                        lo_d   = bus.a;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                    dbz_d   = dbz_save_q;
                end else begin
                    if (div_q) begin
                        acc_d = div_diff[WIDTH]
                              ? {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                              : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (bus.cancel) begin
                    dbz_d = dbz_save_q;
                end else begin
                    hi_d   = res_hi;
                    lo_d   = res_lo;
                    done_d = 1'b1;
                    dbz_d  = div_q && (dvsr_q == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            dvsr_q     <= '0;
            signed_q   <= 1'b0;
            div_q      <= 1'b0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            dbz_save_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            dvsr_q     <= dvsr_d;
            signed_q   <= signed_d;
            div_q      <= div_d;
            a_neg_q    <= a_neg_d;
            b_neg_q    <= b_neg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            dbz_save_q <= dbz_save_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.stall_req   = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: arithmetic reference model compared every cycle, plus directed literal checks.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    muldiv_if bus ();
    muldiv_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic        m_pend = 1'b0, m_done = 1'b0, m_dbz = 1'b0, m_dbz_save = 1'b0, m_res_dbz = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, m_res_hi = '0, m_res_lo = '0;
    int          m_left = 0;
    logic [31:0] nxt_hi, nxt_lo;
    logic        nxt_dbz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    function automatic void ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        hi = '0;
        lo = '0;
        dbz = 1'b0;
        if ((op == MD_DIV || op == MD_DIVU) && b == 32'b0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
            dbz = 1'b1;
        end else begin
            case (op)
                MD_MULT:  begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
                MD_MULTU: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
                MD_DIV:   begin sp = sa / sb; lo = sp[31:0]; sp = sa % sb; hi = sp[31:0]; end
                MD_DIVU:  begin up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0]; end
                default:  ;
            endcase
        end
    endfunction

    always_comb ref_result(bus.op, bus.a, bus.b, nxt_hi, nxt_lo, nxt_dbz);

    // Reference: result is fixed at acceptance and appears 33 edges later unless cancelled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0; m_dbz_save <= 1'b0;
            m_hi <= '0; m_lo <= '0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_pend) begin
                if (bus.start && !bus.cancel) begin
                    if (bus.op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) begin
                        m_pend <= 1'b1; m_left <= 32;
                        m_res_hi <= nxt_hi; m_res_lo <= nxt_lo; m_res_dbz <= nxt_dbz;
                        m_dbz_save <= m_dbz; m_dbz <= 1'b0;
                    end else if (bus.op == MD_MTHI) begin
                        m_hi <= bus.a; m_done <= 1'b1;
                    end else if (bus.op == MD_MTLO) begin
                        m_lo <= bus.a; m_done <= 1'b1;
                    end
                end
            end else if (bus.cancel) begin
                m_pend <= 1'b0; m_dbz <= m_dbz_save;
            end else if (m_left == 0) begin
                m_pend <= 1'b0; m_hi <= m_res_hi; m_lo <= m_res_lo; m_dbz <= m_res_dbz; m_done <= 1'b1;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_busy",      {31'b0, bus.busy},        {31'b0, m_pend});
            chk("cyc_stall_req", {31'b0, bus.stall_req},   {31'b0, m_pend});
            chk("cyc_done",      {31'b0, bus.done},        {31'b0, m_done});
            chk("cyc_dbz",       {31'b0, bus.div_by_zero}, {31'b0, m_dbz});
            chk("cyc_hi",        bus.hi,                   m_hi);
            chk("cyc_lo",        bus.lo,                   m_lo);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcyc);
        lat = -1;
        bcyc = 0;
        for (int n = 0; n <= 40; n++) begin
            if (n > 0) @(negedge clk);
            if (bus.done) begin
                lat = n;
                break;
            end
            if (bus.busy) bcyc++;
        end
    endtask

    initial begin
        int lat, bcyc;
        bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_dbz",  {31'b0, bus.div_by_zero}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(MD_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat, bcyc);
        chk("mult_latency", lat, 32'd33);
        chk("mult_busy_cycles", bcyc, 32'd33);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFF1);

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_done(lat, bcyc);
        chk("multu_hi", bus.hi, 32'h0000_0001);
        chk("multu_lo", bus.lo, 32'hFFFF_FFFE);

        // Start during busy must be ignored.
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = MD_MTHI; bus.a = 32'h77;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat, bcyc);
        chk("divu_ign_latency", lat, 32'd28);
        chk("divu_hi", bus.hi, 32'd2);
        chk("divu_lo", bus.lo, 32'd14);

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bcyc);
        chk("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
        chk("div_neg_lo", bus.lo, 32'hFFFF_FFFD);

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bcyc);
        chk("div_ovf_hi", bus.hi, 32'd0);
        chk("div_ovf_lo", bus.lo, 32'h8000_0000);

        issue(MD_MTHI, 32'h55, 32'd0);
        wait_done(lat, bcyc);
        chk("mthi_latency", lat, 32'd0);
        chk("mthi_busy_cycles", bcyc, 32'd0);
        chk("mthi_hi", bus.hi, 32'h55);
        chk("mthi_lo_kept", bus.lo, 32'h8000_0000);

        issue(MD_DIVU, 32'h1234, 32'd0);
        wait_done(lat, bcyc);
        chk("dbz_latency", lat, 32'd33);
        chk("dbz_hi", bus.hi, 32'h1234);
        chk("dbz_lo", bus.lo, 32'hFFFF_FFFF);
        chk("dbz_flag", {31'b0, bus.div_by_zero}, 32'd1);

        issue(MD_MULTU, 32'd3, 32'd4);
        chk("dbz_cleared", {31'b0, bus.div_by_zero}, 32'd0);
        wait_done(lat, bcyc);
        chk("multu_small_lo", bus.lo, 32'd12);

        issue(MD_MTHI, 32'hAA, 32'd0);
        issue(MD_MTLO, 32'hBB, 32'd0);

        issue(MD_DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        chk("cancel_busy", {31'b0, bus.busy}, 32'd0);
        chk("cancel_done", {31'b0, bus.done}, 32'd0);
        chk("cancel_hi", bus.hi, 32'hAA);
        chk("cancel_lo", bus.lo, 32'hBB);
        repeat (3) @(negedge clk);

        bus.start = 1'b1; bus.op = MD_MTHI; bus.a = 32'h99; bus.cancel = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0;
        chk("idle_cancel_done", {31'b0, bus.done}, 32'd0);
        chk("idle_cancel_hi", bus.hi, 32'hAA);

        issue(3'd6, 32'h12, 32'h34);
        chk("reserved_busy", {31'b0, bus.busy}, 32'd0);
        chk("reserved_done", {31'b0, bus.done}, 32'd0);
        @(negedge clk);

        issue(MD_MULTU, 32'd7, 32'd9);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("midrst_stall", {31'b0, bus.stall_req}, 32'd0);
        chk("midrst_hi", bus.hi, 32'd0);
        chk("midrst_lo", bus.lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
